// File: rtl/ili_pio_in.sv
// Avalon-MM input PIO: 2-flop synchroniser, per-bit debounce, edge capture,
// maskable level interrupt and a write-1-to-clear edge register.
module ili_pio_in #(
    parameter int unsigned       WIDTH           = 1,
    parameter int unsigned       DEBOUNCE_CYCLES = 500,
    parameter int unsigned       EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE     = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] rise, fall, capture, clear;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // A bit is busy while its synchronised level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            busy[i]  = (sync2_q[i] != stable_q[i]);
            if (!busy[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
        if (EDGE_TYPE == 0) begin
            capture = rise;
        end else if (EDGE_TYPE == 1) begin
            capture = fall;
        end else begin
            capture = rise | fall;
        end

        clear     = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
        // Capture is OR-ed in after the clear so a same-edge capture wins.
        edgecap_d = (edgecap_q & ~clear) | capture;

        irqmask_d = irqmask_q;
        if (wr_en && address == 2'd1) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= RESET_VALUE;
            sync2_q   <= RESET_VALUE;
            stable_q  <= RESET_VALUE;
            irqmask_q <= '0;
            edgecap_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[WIDTH-1:0] = stable_q;
            2'd1: readdata[WIDTH-1:0] = irqmask_q;
            2'd2: readdata[WIDTH-1:0] = edgecap_q;
            default: begin
                readdata[WIDTH-1:0] = sync2_q;
                readdata[31]        = |busy;
            end
        endcase
    end

endmodule

// File: tb/tb_ili_pio_in.sv
// Bench for ili_pio_in: directed register/debounce scenarios followed by
// randomized pin and bus traffic checked against a sample-window reference model.
module tb_ili_pio_in;

    localparam int unsigned Deb = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [0:0]  in_port;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic m_sync1 = 1'b1, m_sync2 = 1'b1, m_stable = 1'b1;
    logic m_mask = 1'b0, m_ecap = 1'b0;
    logic hist[$];

    ili_pio_in #(
        .WIDTH(1),
        .DEBOUNCE_CYCLES(Deb),
        .EDGE_TYPE(1),
        .RESET_VALUE(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    model_rd = {31'b0, m_stable};
            2'd1:    model_rd = {31'b0, m_mask};
            2'd2:    model_rd = {31'b0, m_ecap};
            default: model_rd = {(m_sync2 != m_stable), 30'b0, m_sync2};
        endcase
    endfunction

    // Level is accepted once the last Deb synchronised samples all differ from it.
    task automatic model_edge();
        logic new_stable;
        logic all_diff;
        if (reset) begin
            m_sync1 = 1'b1; m_sync2 = 1'b1; m_stable = 1'b1;
            m_mask = 1'b0; m_ecap = 1'b0;
            hist.delete();
            return;
        end
        hist.push_back(m_sync2);
        if (hist.size() > Deb) void'(hist.pop_front());
        all_diff = (hist.size() == Deb);
        foreach (hist[i]) if (hist[i] == m_stable) all_diff = 1'b0;
        new_stable = all_diff ? ~m_stable : m_stable;
        if (chipselect && !write_n && address == 2'd2 && writedata[0]) m_ecap = 1'b0;
        if (chipselect && !write_n && address == 2'd1) m_mask = writedata[0];
        if (m_stable && !new_stable) m_ecap = 1'b1;
        if (new_stable != m_stable) hist.delete();
        m_stable = new_stable;
        m_sync2  = m_sync1;
        m_sync1  = in_port[0];
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("irq_model", {31'b0, irq}, {31'b0, m_ecap & m_mask});
        check_eq("rd_model", readdata, model_rd(address));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check_eq(tag, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    initial begin
        reset = 1'b1; in_port = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0;

        // Reset state
        steps(3);
        reset = 1'b0;
        rd(2'd0, 32'h1, "rst_data");
        rd(2'd1, 32'h0, "rst_mask");
        rd(2'd2, 32'h0, "rst_edgecap");
        rd(2'd3, 32'h1, "rst_status");
        check_eq("rst_irq", {31'b0, irq}, 32'h0);

        // Short low pulse is filtered
        in_port = 1'b0; steps(3);
        in_port = 1'b1; steps(8);
        rd(2'd0, 32'h1, "glitch_data");
        rd(2'd2, 32'h0, "glitch_edgecap");

        // Sustained low accepted on the sixth edge
        in_port = 1'b0; steps(5);
        rd(2'd0, 32'h1, "deb_data_e5");
        step();
        rd(2'd0, 32'h0, "deb_data_e6");
        rd(2'd2, 32'h1, "deb_edgecap_e6");
        check_eq("deb_irq_masked", {31'b0, irq}, 32'h0);

        // Interrupt path
        wr(2'd2, 32'h1);
        wr(2'd1, 32'h1);
        in_port = 1'b1; steps(8);
        check_eq("int_rise_no_irq", {31'b0, irq}, 32'h0);
        in_port = 1'b0; steps(6);
        check_eq("int_irq_set", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        check_eq("int_irq_clr", {31'b0, irq}, 32'h0);
        rd(2'd2, 32'h0, "int_edgecap_clr");

        // Capture wins over a same-edge clear
        in_port = 1'b1; steps(8);
        in_port = 1'b0; steps(6);
        in_port = 1'b1; steps(8);
        in_port = 1'b0; steps(5);
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h1, "simul_edgecap");
        check_eq("simul_irq", {31'b0, irq}, 32'h1);

        // Masked capture then unmask
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h1);
        in_port = 1'b1; steps(8);
        in_port = 1'b0; steps(6);
        rd(2'd2, 32'h1, "masked_edgecap");
        check_eq("masked_irq", {31'b0, irq}, 32'h0);
        wr(2'd1, 32'h1);
        check_eq("unmask_irq", {31'b0, irq}, 32'h1);

        // Reset mid-debounce
        wr(2'd2, 32'h1);
        in_port = 1'b1; steps(8);
        in_port = 1'b0; steps(4);
        rd(2'd3, 32'h8000_0000, "middeb_status");
        in_port = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0;
        rd(2'd0, 32'h1, "middeb_rst_data");
        rd(2'd3, 32'h1, "middeb_rst_status");
        rd(2'd2, 32'h0, "middeb_rst_edgecap");
        steps(8);
        check_eq("middeb_no_irq", {31'b0, irq}, 32'h0);
        rd(2'd2, 32'h0, "middeb_edgecap_late");

        // Randomized pin runs and bus traffic
        for (int blk = 0; blk < 400; blk++) begin
            in_port = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'($urandom_range(1, 9)); k++) begin
                reset      = ($urandom_range(0, 99) == 0);
                chipselect = 1'($urandom_range(0, 1));
                write_n    = ($urandom_range(0, 3) != 0);
                address    = 2'($urandom_range(0, 3));
                writedata  = $urandom;
                step();
            end
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
